ex_mdu: RTL and testbench
=========================

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (any even value >= 8).
REQ-002 SHALL have parameter TAG_W, default 5, width of the opaque tag carried with each operation (rd index).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  abort in-flight operation.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  unit can accept a request.
REQ-008 SHALL have port req_op  input  3  RV32M funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
REQ-009 SHALL have port req_a  input  XLEN  rs1 value, already forwarded.
REQ-010 SHALL have port req_b  input  XLEN  rs2 value, already forwarded.
REQ-011 SHALL have port req_tag  input  TAG_W  tag returned with the result.
REQ-012 SHALL have port resp_valid  output  1  result present.
REQ-013 SHALL have port resp_ready  input  1  consumer takes result.
REQ-014 SHALL have port resp_result  output  XLEN  result.
REQ-015 SHALL have port resp_tag  output  TAG_W  tag of the result.
REQ-016 SHALL have port busy  output  1  state != IDLE, used by hazard unit to stall EX.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-018 req_ready SHALL equal (state == IDLE); a request is accepted on an edge where req_valid && req_ready && !flush.
REQ-019 On acceptance, operands SHALL be latched as magnitudes (signed per op: mulh both, mulhsu a only, div/rem both), signs and op recorded, and the FSM SHALL move to BUSY with step counter 0.
REQ-020 BUSY SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle over a 2*XLEN-bit accumulator; after XLEN steps the FSM SHALL move to FIX.
REQ-021 FIX SHALL apply two's-complement sign correction and select the low half (mul), high half (mulh*), quotient (div*) or remainder (rem*), then move to DONE.
REQ-022 Normal latency SHALL be XLEN+2 edges from acceptance to resp_valid high (34 for XLEN=32).
REQ-023 Divide by zero SHALL bypass BUSY: IDLE->DONE on acceptance; div/divu result all ones, rem/remu result = req_a.
REQ-024 Signed overflow (req_a = most negative, req_b = -1, op div/rem) SHALL bypass BUSY: div result = most negative, rem result = 0.
REQ-025 Remainder sign SHALL follow dividend; quotient SHALL truncate toward zero.
REQ-026 resp_valid SHALL equal (state == DONE); resp_result and resp_tag SHALL be stable while resp_valid && !resp_ready.
REQ-027 DONE SHALL move to IDLE on resp_ready; no new request is accepted in the same edge (one op per XLEN+3 cycles minimum).
REQ-028 flush SHALL force IDLE on the next edge from any state, discard result, override resp_ready and req_valid, and produce no response.
REQ-029 Step counter SHALL be $clog2(XLEN)+1 bits and SHALL not wrap during an operation.

Reset
REQ-030 On rst low, state SHALL be IDLE, counter 0, accumulator/operands/tag 0, asynchronously.
REQ-031 Outputs during reset SHALL be req_ready=1, resp_valid=0, busy=0, resp_result=0, resp_tag=0.
REQ-032 Reset asserted mid-operation SHALL abandon it; no response after reset release.

Structure
REQ-033 mdu_op_t enum (funct3 encodings) and mdu_state_t SHALL live in rv32i_types.
REQ-034 Datapath SHALL be one sub-module mdu_core (accumulator and step logic); ex_mdu holds FSM, handshake and special-case bypass.

Verification
REQ-035 mul 7 x -3, XLEN=32 -> resp_result 0xFFFFFFEB, resp_valid after 34 edges, tag echoed.
REQ-036 mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 div -7/2 -> 0xFFFFFFFD, rem -7/2 -> 0xFFFFFFFF; divu 100/0 -> 0xFFFFFFFF after 1 edge; div 0x80000000/-1 -> 0x80000000 after 1 edge.
REQ-038 resp_ready held low 5 cycles after DONE -> result/tag stable, req_ready low, then IDLE one edge after resp_ready.
REQ-039 flush at step 10 of div -> IDLE next edge, resp_valid never asserted, next request completes correctly.
REQ-040 rst low at step 20, XLEN=16 instance -> outputs at reset values immediately; next op latency 18 edges.

Source files
------------

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared types for the RV32M multiply/divide unit.
//   mdu_op_t    : RV32M funct3 encodings (mul .. remu)
//   mdu_state_t : control FSM states of ex_mdu
// Helper functions classify an operation as divide / signed-operand.
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_t;

   // True for div, divu, rem, remu.
   function automatic logic op_is_div(input mdu_op_t op);
      logic r;
      case (op)
         MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: r = 1'b1;
         default:                              r = 1'b0;
      endcase
      return r;
   endfunction

   // rs1 is interpreted as signed for mulh, mulhsu, div, rem.
   function automatic logic op_a_signed(input mdu_op_t op);
      logic r;
      case (op)
         MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

   // rs2 is interpreted as signed for mulh, div, rem.
   function automatic logic op_b_signed(input mdu_op_t op);
      logic r;
      case (op)
         MDU_MULH, MDU_DIV, MDU_REM: r = 1'b1;
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core
// Iterative datapath: a 2*XLEN-bit accumulator doing one shift-add multiply
// step or one restoring shift-subtract divide step per i_step.
//   clk, rst     : clock, asynchronous active-low reset
//   i_clr        : synchronous clear of the step counter (flush)
//   i_load       : load magnitudes, clear counter, select mul/div mode
//   i_step       : perform one iteration
//   i_is_div     : mode for the loaded operation
//   i_a_mag/b_mag: unsigned operand magnitudes
//   o_last       : the current step is the final (XLEN-th) one
//   o_acc        : accumulator; mul -> {hi,lo} product, div -> {rem,quo}
// -----------------------------------------------------------------------------
module mdu_core #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_is_div,
   input  logic [XLEN-1:0]   i_a_mag,
   input  logic [XLEN-1:0]   i_b_mag,
   output logic              o_last,
   output logic [2*XLEN-1:0] o_acc
);

   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_b;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_div;

   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_trial;
   logic [XLEN-1:0]   w_diff;
   logic              w_fits;
   logic [2*XLEN-1:0] w_acc_nxt;

   // Next accumulator value for one multiply or divide iteration.
   always_comb begin
      // Multiply: add b into the high half when the multiplier LSB is set,
      // then shift the whole {carry,hi,lo} right by one.
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                  (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
      // Divide: the partial remainder shifted left by one, including the bit
      // that leaves the high half, is XLEN+1 bits wide.
      w_trial   = r_acc[2*XLEN-1:XLEN-1];
      w_fits    = (w_trial >= {1'b0, r_b});
      // When it fits the difference is below b, so XLEN bits are enough.
      w_diff    = w_trial[XLEN-1:0] - r_b;
      if (r_is_div) begin
         if (w_fits) begin
            w_acc_nxt = {w_diff, r_acc[XLEN-2:0], 1'b1};
         end else begin
            w_acc_nxt = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
         end
      end else begin
         w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
      end
   end

   // Accumulator, divisor/multiplicand and mode registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc    <= '0;
         r_b      <= '0;
         r_is_div <= 1'b0;
      end else if (i_load) begin
         r_acc    <= {{XLEN{1'b0}}, i_a_mag};
         r_b      <= i_b_mag;
         r_is_div <= i_is_div;
      end else if (i_step) begin
         r_acc    <= w_acc_nxt;
      end else begin
         r_acc    <= r_acc;
      end
   end

   // Step counter; runs 0..XLEN so it never wraps inside an operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr || i_load) begin
         r_cnt <= '0;
      end else if (i_step) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_last = (r_cnt == CNT_W'(XLEN - 1));
   assign o_acc  = r_acc;

endmodule

// File: rtl/ex_mdu.sv
// -----------------------------------------------------------------------------
// ex_mdu
// RV32M multiply/divide execution unit: control FSM, request/response
// handshake, divide-by-zero and signed-overflow bypass, sign fix-up.
//   clk, rst                : clock, asynchronous active-low reset
//   flush                   : abort any operation, no response produced
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_op/req_a/req_b/req_tag : funct3, operands, opaque tag
//   resp_valid/resp_ready   : response handshake (valid only in DONE)
//   resp_result/resp_tag    : result and echoed tag, held while stalled
//   busy                    : unit not IDLE
// -----------------------------------------------------------------------------
module ex_mdu
   import rv32i_types::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_t        r_state;
   mdu_state_t        w_state_nxt;
   mdu_op_t           r_op;
   logic              r_a_neg;
   logic              r_b_neg;
   logic [XLEN-1:0]   r_result;
   logic [TAG_W-1:0]  r_tag;

   mdu_op_t           w_op;
   logic              w_accept;
   logic              w_div_zero;
   logic              w_ovf;
   logic              w_bypass;
   logic [XLEN-1:0]   w_byp_res;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic              w_load;
   logic              w_step;
   logic              w_last;
   logic [2*XLEN-1:0] w_acc;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_res;

   assign w_op       = mdu_op_t'(req_op);
   assign w_accept   = req_valid && (r_state == IDLE) && !flush;
   assign w_div_zero = op_is_div(w_op) && (req_b == {XLEN{1'b0}});
   assign w_ovf      = ((w_op == MDU_DIV) || (w_op == MDU_REM)) &&
                       (req_a == MOST_NEG) && (req_b == {XLEN{1'b1}});
   assign w_bypass   = w_div_zero || w_ovf;
   assign w_a_neg    = op_a_signed(w_op) && req_a[XLEN-1];
   assign w_b_neg    = op_b_signed(w_op) && req_b[XLEN-1];
   assign w_a_mag    = w_a_neg ? (~req_a + {{(XLEN-1){1'b0}}, 1'b1}) : req_a;
   assign w_b_mag    = w_b_neg ? (~req_b + {{(XLEN-1){1'b0}}, 1'b1}) : req_b;
   assign w_load     = w_accept && !w_bypass;
   assign w_step     = (r_state == BUSY) && !flush;

   mdu_core #(
      .XLEN (XLEN)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (flush),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_is_div (op_is_div(w_op)),
      .i_a_mag  (w_a_mag),
      .i_b_mag  (w_b_mag),
      .o_last   (w_last),
      .o_acc    (w_acc)
   );

   // Result of a bypassed divide (divide by zero or signed overflow).
   always_comb begin
      w_byp_res = {XLEN{1'b0}};
      if (w_div_zero) begin
         if ((w_op == MDU_DIV) || (w_op == MDU_DIVU)) begin
            w_byp_res = {XLEN{1'b1}};
         end else begin
            w_byp_res = req_a;
         end
      end else if (w_ovf) begin
         if (w_op == MDU_DIV) begin
            w_byp_res = MOST_NEG;
         end else begin
            w_byp_res = {XLEN{1'b0}};
         end
      end else begin
         w_byp_res = {XLEN{1'b0}};
      end
   end

   // Sign correction of the magnitude result and half/quotient selection.
   always_comb begin
      w_prod = (r_a_neg ^ r_b_neg) ? (~w_acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : w_acc;
      // Quotient truncates toward zero; remainder takes the dividend's sign.
      w_quo  = (r_a_neg ^ r_b_neg) ? (~w_acc[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                                   : w_acc[XLEN-1:0];
      w_rem  = r_a_neg ? (~w_acc[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                       : w_acc[2*XLEN-1:XLEN];
      case (r_op)
         MDU_MUL:                          w_fix_res = w_prod[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:                w_fix_res = w_quo;
         MDU_REM, MDU_REMU:                w_fix_res = w_rem;
         default:                          w_fix_res = {XLEN{1'b0}};
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; flush wins over every handshake.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_state_nxt = w_bypass ? DONE : BUSY;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            BUSY: begin
               if (w_last) begin
                  w_state_nxt = FIX;
               end else begin
                  w_state_nxt = BUSY;
               end
            end
            FIX:  w_state_nxt = DONE;
            DONE: begin
               if (resp_ready) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DONE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Operation context captured at acceptance and the registered result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op     <= MDU_MUL;
         r_a_neg  <= 1'b0;
         r_b_neg  <= 1'b0;
         r_tag    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op     <= w_op;
         r_a_neg  <= w_a_neg;
         r_b_neg  <= w_b_neg;
         r_tag    <= req_tag;
         r_result <= w_bypass ? w_byp_res : r_result;
      end else if ((r_state == FIX) && !flush) begin
         r_result <= w_fix_res;
      end else begin
         r_result <= r_result;
      end
   end

   assign req_ready   = (r_state == IDLE);
   assign resp_valid  = (r_state == DONE);
   assign busy        = (r_state != IDLE);
   assign resp_result = r_result;
   assign resp_tag    = r_tag;

endmodule

// File: tb/tb_ex_mdu.sv
// -----------------------------------------------------------------------------
// tb_ex_mdu
// Directed bench for ex_mdu: a 32-bit and a 16-bit instance sharing clock and
// reset. Latency is counted with the acceptance edge as edge 1.
// -----------------------------------------------------------------------------
module tb_ex_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;

   logic        req_valid, req_ready, resp_valid, resp_ready, busy;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b, resp_result;
   logic [4:0]  req_tag, resp_tag;

   logic        h_req_valid, h_req_ready, h_resp_valid, h_resp_ready, h_busy;
   logic [2:0]  h_req_op;
   logic [15:0] h_req_a, h_req_b, h_resp_result;
   logic [4:0]  h_req_tag, h_resp_tag;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_mdu #(.XLEN(32), .TAG_W(5)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
   );

   ex_mdu #(.XLEN(16), .TAG_W(5)) u_dut16 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .req_valid(h_req_valid), .req_ready(h_req_ready), .req_op(h_req_op),
      .req_a(h_req_a), .req_b(h_req_b), .req_tag(h_req_tag),
      .resp_valid(h_resp_valid), .resp_ready(h_resp_ready),
      .resp_result(h_resp_result), .resp_tag(h_resp_tag), .busy(h_busy)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Issue one op on the 32-bit unit, wait for the response, check, retire it.
   task automatic op32(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp_res, input int exp_lat);
      int lat;
      chk({name, "_rdy"}, 64'(req_ready), 64'd1);
      req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({name, "_res"}, 64'(resp_result), 64'(exp_res));
      chk({name, "_tag"}, 64'(resp_tag), 64'(tag));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({name, "_idle"}, 64'({busy, resp_valid, req_ready}), 64'd1);
   endtask

   // Same for the 16-bit unit.
   task automatic op16(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] tag,
                       input logic [15:0] exp_res, input int exp_lat);
      int lat;
      h_req_op = op; h_req_a = a; h_req_b = b; h_req_tag = tag; h_req_valid = 1'b1;
      @(posedge clk); #1;
      h_req_valid = 1'b0;
      lat = 1;
      while (!h_resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({name, "_res"}, 64'(h_resp_result), 64'(exp_res));
      chk({name, "_tag"}, 64'(h_resp_tag), 64'(tag));
      h_resp_ready = 1'b1;
      @(posedge clk); #1;
      h_resp_ready = 1'b0;
      chk({name, "_idle"}, 64'({h_busy, h_resp_valid, h_req_ready}), 64'd1);
   endtask

   initial begin
      int lat;
      int seen;
      rst = 1'b0; flush = 1'b0;
      req_valid = 1'b0; resp_ready = 1'b0; req_op = 3'd0;
      req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0;
      h_req_valid = 1'b0; h_resp_ready = 1'b0; h_req_op = 3'd0;
      h_req_a = 16'd0; h_req_b = 16'd0; h_req_tag = 5'd0;

      // Reset values
      #12;
      chk("rst_hs32", 64'({busy, resp_valid, req_ready}), 64'd1);
      chk("rst_res32", 64'(resp_result), 64'd0);
      chk("rst_tag32", 64'(resp_tag), 64'd0);
      chk("rst_hs16", 64'({h_busy, h_resp_valid, h_req_ready}), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Main function, normal latency 34
      op32("mul",    3'b000, 32'd7,          32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 34);
      op32("mulh",   3'b001, 32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 34);
      op32("mulhu",  3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34);
      op32("mulhsu", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 34);
      op32("mulhu2", 3'b011, 32'h00010000,   32'h00010000, 5'd4,  32'h00000001, 34);
      op32("div",    3'b100, 32'hFFFFFFF9,   32'd2,        5'd5,  32'hFFFFFFFD, 34);
      op32("rem",    3'b110, 32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF, 34);
      op32("rem_pn", 3'b110, 32'd7,          32'hFFFFFFFE, 5'd7,  32'h00000001, 34);
      op32("divu",   3'b101, 32'd100,        32'd7,        5'd8,  32'd14,       34);
      op32("remu",   3'b111, 32'd100,        32'd7,        5'd10, 32'd2,        34);

      // Bypass cases, latency 1
      op32("divu0",  3'b101, 32'd100,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
      op32("remu0",  3'b111, 32'h00001234,   32'd0,        5'd12, 32'h00001234, 1);
      op32("divovf", 3'b100, 32'h80000000,   32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
      op32("removf", 3'b110, 32'h80000000,   32'hFFFFFFFF, 5'd14, 32'h00000000, 1);

      // Response back-pressure
      req_op = 3'b000; req_a = 32'd7; req_b = 32'hFFFFFFFD; req_tag = 5'd3; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_busy", 64'({busy, req_ready}), 64'd2);
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_lat", 64'(lat), 64'd34);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_res", 64'(resp_result), 64'hFFFFFFEB);
         chk("bp_tag", 64'(resp_tag), 64'd3);
         chk("bp_hs", 64'({resp_valid, req_ready}), 64'd2);
      end
      req_op = 3'b101; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd30;
      req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; resp_ready = 1'b0;
      chk("bp_ret", 64'({busy, resp_valid, req_ready}), 64'd1);
      @(posedge clk); #1;
      chk("bp_noacc", 64'({busy, resp_valid, req_ready}), 64'd1);

      // Flush in IDLE overrides req_valid
      req_op = 3'b000; req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      chk("fl_idle", 64'({busy, resp_valid, req_ready}), 64'd1);

      // Flush at step 10 of a divide
      seen = 0;
      req_op = 3'b100; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd4; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         seen += int'(resp_valid);
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_state", 64'({busy, resp_valid, req_ready}), 64'd1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen += int'(resp_valid);
      end
      chk("fl_noresp", 64'(seen), 64'd0);
      op32("fl_next", 3'b101, 32'd1000, 32'd3, 5'd15, 32'd333, 34);

      // Reset mid-operation on both instances
      req_op = 3'b100; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd17; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      h_req_op = 3'b000; h_req_a = 16'd5; h_req_b = 16'd6; h_req_tag = 5'd18; h_req_valid = 1'b1;
      @(posedge clk); #1;
      h_req_valid = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      #2;
      rst = 1'b0;
      #1;
      chk("rr_hs32", 64'({busy, resp_valid, req_ready}), 64'd1);
      chk("rr_res32", 64'(resp_result), 64'd0);
      chk("rr_tag32", 64'(resp_tag), 64'd0);
      chk("rr_hs16", 64'({h_busy, h_resp_valid, h_req_ready}), 64'd1);
      chk("rr_tag16", 64'(h_resp_tag), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         seen += int'(resp_valid) + int'(h_resp_valid);
      end
      chk("rr_noresp", 64'(seen), 64'd0);
      op16("m16",    3'b000, 16'd7,   16'hFFFD, 5'd21, 16'hFFEB, 18);
      op16("divu16", 3'b101, 16'd100, 16'd7,    5'd22, 16'd14,   18);
      op32("post",   3'b011, 32'h00010000, 32'h00010000, 5'd23, 32'h00000001, 34);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
